// File: rtl/uart_frame_rx_ctrl.sv
// Frame controller behind a UART receiver: hunts SYNC, parses LEN/PAYLOAD/CHK,
// buffers the payload and releases it on a valid/ready stream once the checksum passes.
module uart_frame_rx_ctrl #(
  parameter int unsigned MAX_LEN   = 16,      // 1..255 (LEN is a single byte)
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 100000   // >= 2
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic [7:0] o_payload,
  output logic       o_payload_valid,
  input  logic       i_payload_ready,
  output logic       o_payload_last,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic          valid_d;
  logic          ev;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [7:0]    chk_sum;
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [MAX_LEN];
  logic [1:0]    err_code;
  logic          frame_ok;
  logic          frame_err;
  logic          overrun;
  logic          in_frame;
  logic          tmo;
  logic          xfer;
  logic          rd_last;

  // A held-high valid is one byte; only its rising edge counts.
  assign ev       = i_byte_valid & ~valid_d;
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo      = in_frame && !ev && (tcnt == T_LAST);
  assign xfer     = (state == S_DRAIN) && i_payload_ready;
  assign rd_last  = (rd_ptr == len - 8'd1);
  assign chk_sum  = sum + i_byte;

  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && ev) mem[wr_ptr[AW-1:0]] <= i_byte;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= S_HUNT;
      valid_d   <= 1'b1;
      len       <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tcnt      <= '0;
      err_code  <= ERR_NONE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_d   <= i_byte_valid;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Every state entry inside a frame coincides with ev, so this also clears on entry.
      if (ev || !in_frame) tcnt <= '0;
      else                 tcnt <= tcnt + 1'b1;

      case (state)
        S_HUNT: begin
          if (ev && i_byte == SYNC_BYTE) state <= S_LEN;
        end
        S_LEN: begin
          if (ev) begin
            len    <= i_byte;
            sum    <= i_byte;
            wr_ptr <= '0;
            if (32'(i_byte) > MAX_LEN) begin
              state     <= S_HUNT;
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
            end else if (i_byte == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (ev) begin
            sum    <= chk_sum;
            wr_ptr <= wr_ptr + 8'd1;
            if (wr_ptr + 8'd1 == len) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (ev) begin
            if (chk_sum == 8'h00) begin
              frame_ok <= 1'b1;
              err_code <= ERR_NONE;
              rd_ptr   <= '0;
              state    <= (len == 8'd0) ? S_HUNT : S_DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= S_HUNT;
            end
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            rd_ptr <= rd_ptr + 8'd1;
            if (rd_last) state <= S_HUNT;
          end
          // The parser is busy draining; incoming bytes (even SYNC) are lost.
          if (ev) overrun <= 1'b1;
        end
        default: state <= S_HUNT;
      endcase

      if (tmo) begin
        state     <= S_HUNT;
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
      end
    end
  end

  assign o_payload_valid = (state == S_DRAIN);
  assign o_payload       = o_payload_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign o_payload_last  = o_payload_valid && rd_last;
  assign o_frame_ok      = frame_ok;
  assign o_frame_err     = frame_err;
  assign o_err_code      = err_code;
  assign o_overrun       = overrun;
  assign o_busy          = (state != S_HUNT);

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Randomized self-checking bench for uart_frame_rx_ctrl against a byte-stream frame model.
module tb_uart_frame_rx_ctrl;
  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 300;
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef logic [7:0] bq_t[$];
  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic [7:0] o_payload;
  logic       o_payload_valid;
  logic       i_payload_ready = 1'b0;
  logic       o_payload_last;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic       o_overrun;
  logic       o_busy;

  uart_frame_rx_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .i_reset(i_reset), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_payload(o_payload), .o_payload_valid(o_payload_valid), .i_payload_ready(i_payload_ready),
    .o_payload_last(o_payload_last), .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err),
    .o_err_code(o_err_code), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ev_cyc = 0;
  int idle_cyc = 0;
  int exp_code = 0;
  int rdy_mode = 0;  // 0 low, 1 high, 2 random

  int    ok_cyc_q[$];
  int    err_cyc_q[$];
  int    err_code_q[$];
  int    pl_cyc_q[$];
  bq_t   pl_q;
  bitq_t last_q;
  int    ovr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       i_payload_ready = 1'b0;
      1:       i_payload_ready = 1'b1;
      default: i_payload_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [7:0] prev_pl = 8'h00;
  bit         prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_frame_ok) ok_cyc_q.push_back(cyc);
      if (o_frame_err) begin err_cyc_q.push_back(cyc); err_code_q.push_back(int'(o_err_code)); end
      if (o_overrun) ovr_cnt++;
      if (o_payload_valid && i_payload_ready) begin
        pl_q.push_back(o_payload); last_q.push_back(o_payload_last); pl_cyc_q.push_back(cyc);
      end
      if (o_frame_ok || o_frame_err) begin
        total++;
        if (o_frame_ok && o_frame_err) begin
          bad++; $display("FAIL ok_err_exclusive: ok=%b err=%b at cycle %0d, required not both", o_frame_ok, o_frame_err, cyc);
        end
      end
      if (prev_stall) begin
        total++;
        if (!o_payload_valid || o_payload !== prev_pl) begin
          bad++; $display("FAIL stall_stable: valid=%b payload=%h, required valid=1 payload=%h", o_payload_valid, o_payload, prev_pl);
        end
      end
    end
    prev_stall = !i_reset && o_payload_valid && !i_payload_ready;
    prev_pl    = o_payload;
  end

  // Reference: scan a byte stream for frames using the frame rules alone (no timing).
  function automatic void model(input bq_t s, inout int code, output int n_ok, output int n_err,
                                output bq_t pl, output bitq_t lst);
    int i;
    int len;
    logic [7:0] sum;
    i = 0; n_ok = 0; n_err = 0; pl = {}; lst = {};
    while (i < s.size()) begin
      if (s[i] != SYNC) begin i++; continue; end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len > MAX_LEN) begin n_err++; code = 1; i += 2; continue; end
      if (i + 2 + len >= s.size()) break;
      sum = 8'(len);
      for (int j = 0; j <= len; j++) sum = sum + s[i+2+j];
      if (sum == 8'h00) begin
        n_ok++; code = 0;
        for (int j = 0; j < len; j++) begin pl.push_back(s[i+2+j]); lst.push_back(j == len - 1); end
      end else begin
        n_err++; code = 2;
      end
      i += 3 + len;
    end
  endfunction

  function automatic bq_t make_frame(input int len, input bit bad_chk);
    bq_t s;
    logic [7:0] sum;
    s = {SYNC, 8'(len)};
    sum = 8'(len);
    for (int j = 0; j < len; j++) begin
      s.push_back(8'($urandom)); sum = sum + s[s.size()-1];
    end
    sum = 8'h00 - sum;
    if (bad_chk) sum = sum ^ (8'h01 << $urandom_range(0, 7));
    s.push_back(sum);
    return s;
  endfunction

  task automatic clear_mon();
    ok_cyc_q = {}; err_cyc_q = {}; err_code_q = {}; pl_cyc_q = {}; pl_q = {}; last_q = {}; ovr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    i_byte = b; i_byte_valid = 1'b1;
    @(posedge clk); #1; ev_cyc = cyc;
    repeat (hold - 1) begin @(posedge clk); #1; end
    i_byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (!o_busy) begin seen = 1'b1; idle_cyc = cyc; end
    end
    if (!seen) begin
      total++; bad++; $display("FAIL %s_idle: busy=%b after 3000 cycles, required 0", name, o_busy);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string name, input bq_t s, input int hold, input int gap_max);
    int n_ok, n_err, mism;
    bq_t pl;
    bitq_t lst;
    clear_mon();
    model(s, exp_code, n_ok, n_err, pl, lst);
    foreach (s[k]) send_byte(s[k], hold, $urandom_range(1, gap_max));
    wait_idle(name);
    total++;
    if (ok_cyc_q.size() != n_ok) begin bad++; $display("FAIL %s_ok: got %0d pulses, required %0d", name, ok_cyc_q.size(), n_ok); end
    total++;
    if (err_cyc_q.size() != n_err) begin bad++; $display("FAIL %s_err: got %0d pulses, required %0d", name, err_cyc_q.size(), n_err); end
    total++;
    if (o_err_code !== 2'(exp_code)) begin bad++; $display("FAIL %s_code: got %0d, required %0d", name, o_err_code, exp_code); end
    total++;
    if (pl_q.size() != pl.size()) begin
      bad++; $display("FAIL %s_plen: got %0d bytes, required %0d", name, pl_q.size(), pl.size());
    end else begin
      mism = 0;
      foreach (pl[k]) if (pl_q[k] !== pl[k] || last_q[k] != lst[k]) mism++;
      total++;
      if (mism != 0) begin bad++; $display("FAIL %s_pdata: %0d byte/last mismatches, required 0", name, mism); end
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({o_payload, o_payload_valid, o_payload_last, o_frame_ok, o_frame_err, o_err_code, o_overrun, o_busy} !== 16'h0) begin
      bad++;
      $display("FAIL %s: pl=%h v=%b last=%b ok=%b err=%b code=%0d ovr=%b busy=%b, required all 0", name,
               o_payload, o_payload_valid, o_payload_last, o_frame_ok, o_frame_err, o_err_code, o_overrun, o_busy);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_byte = SYNC; i_byte_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); check_zero("reset_outputs");
    @(posedge clk); #1; i_reset = 1'b0; exp_code = 0;
    repeat (3) begin @(posedge clk); #1; end
    i_byte_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL held_across_reset: busy=%b, required 0", o_busy); end
    @(posedge clk); #1;
    clear_mon();
  endtask

  task automatic test_basic();
    rdy_mode = 1;
    run_frame("basic", '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 1, 1);
    total++;
    if (pl_cyc_q.size() != 3 || pl_cyc_q[2] - pl_cyc_q[0] != 2) begin
      bad++; $display("FAIL basic_consecutive: %0d transfers, required 3 on consecutive cycles", pl_cyc_q.size());
    end else begin
      total++;
      if (idle_cyc != pl_cyc_q[2] + 1) begin
        bad++; $display("FAIL basic_busy_fall: idle at cycle %0d, required %0d", idle_cyc, pl_cyc_q[2] + 1);
      end
    end
  endtask

  task automatic test_bad_chk();
    rdy_mode = 1;
    run_frame("bad_chk", '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98}, 1, 2);
  endtask

  task automatic test_len_err();
    rdy_mode = 1;
    run_frame("len_err", '{SYNC, 8'h11}, 1, 2);
    run_frame("len_zero", '{SYNC, 8'h00, 8'h00}, 1, 2);
    run_frame("len_max", make_frame(MAX_LEN, 1'b0), 1, 2);
  endtask

  task automatic test_timeout();
    bq_t s;
    rdy_mode = 1;
    clear_mon();
    send_byte(SYNC, 1, 1); send_byte(8'h02, 1, 1); send_byte(8'hAA, 1, 1);
    for (int k = 0; k < TIMEOUT + 50 && err_cyc_q.size() == 0; k++) begin @(posedge clk); #1; end
    total++;
    if (err_cyc_q.size() != 1) begin
      bad++; $display("FAIL tmo_pulse: got %0d err pulses, required 1", err_cyc_q.size());
    end else begin
      total++;
      if (err_cyc_q[0] != ev_cyc + TIMEOUT) begin
        bad++; $display("FAIL tmo_cycle: err at %0d, required %0d", err_cyc_q[0], ev_cyc + TIMEOUT);
      end
      total++;
      if (err_code_q[0] != 3) begin bad++; $display("FAIL tmo_code: got %0d, required 3", err_code_q[0]); end
    end
    exp_code = 3;
    wait_idle("tmo");
    total++;
    if (ok_cyc_q.size() != 0) begin bad++; $display("FAIL tmo_no_ok: got %0d ok pulses, required 0", ok_cyc_q.size()); end
    run_frame("after_tmo", make_frame($urandom_range(1, MAX_LEN), 1'b0), 1, 2);
    // Byte arriving exactly on the would-be timeout edge is still taken.
    s = make_frame(2, 1'b0);
    clear_mon();
    foreach (s[k]) send_byte(s[k], 1, TIMEOUT - 1);
    wait_idle("tmo_edge");
    total++;
    if (ok_cyc_q.size() != 1 || err_cyc_q.size() != 0) begin
      bad++; $display("FAIL tmo_edge: ok=%0d err=%0d, required ok=1 err=0", ok_cyc_q.size(), err_cyc_q.size());
    end
    exp_code = 0;
  endtask

  task automatic test_held_valid();
    bq_t s;
    rdy_mode = 1;
    s = make_frame(3, 1'b0);
    s.push_front(8'hFF); s.push_front(8'h00);
    run_frame("held_valid", s, 100, 3);
  endtask

  task automatic test_drain();
    bq_t s;
    int mism;
    rdy_mode = 0;
    s = make_frame(4, 1'b0);
    clear_mon();
    foreach (s[k]) send_byte(s[k], 1, 1);
    mism = 0;
    repeat (20) begin
      @(negedge clk);
      if (!o_payload_valid || o_payload !== s[2]) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL drain_hold: %0d cycles off, required payload %h held valid", mism, s[2]); end
    @(posedge clk); #1;
    send_byte(SYNC, 1, 2);
    total++;
    if (ovr_cnt != 1 || o_busy !== 1'b1) begin
      bad++; $display("FAIL drain_overrun: overruns=%0d busy=%b, required 1 and 1", ovr_cnt, o_busy);
    end
    total++;
    if (ok_cyc_q.size() != 1 || pl_q.size() != 0) begin
      bad++; $display("FAIL drain_state: ok=%0d transfers=%0d, required 1 and 0", ok_cyc_q.size(), pl_q.size());
    end
    i_reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); check_zero("drain_reset_in");
    @(posedge clk); #1; i_reset = 1'b0; exp_code = 0;
    @(negedge clk); check_zero("drain_reset_out");
    @(posedge clk); #1;
  endtask

  task automatic test_random(input string tag, input int n, input int hold_max, input int gap_max);
    bq_t s;
    int kind;
    logic [7:0] b;
    for (int f = 0; f < n; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) s = '{SYNC, 8'($urandom_range(MAX_LEN + 1, 255))};
      else           s = make_frame($urandom_range(0, MAX_LEN), kind == 1);
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h3C;
        s.push_front(b);
      end
      rdy_mode = 2;
      run_frame($sformatf("%s%0d", tag, f), s, $urandom_range(1, hold_max), gap_max);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_held_valid();
    test_drain();
    test_random("b2b", 30, 1, 1);
    test_random("rnd", 30, 4, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
